// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order queue of fetch predictions resolved in EX into BPU hit/mispredict; BRU_STATS_EN adds pop/mispredict counters.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PC_WIDTH = 9
) (
  input  logic                in_Clk,
  input  logic                in_Rst_N,
  input  logic                in_pred_valid,
  input  logic [PC_WIDTH-1:0] in_PC,
  input  logic                in_pred_bimodal,
  input  logic                in_pred_gshare,
  input  logic                in_pred_final,
  input  logic                in_res_valid,
  input  logic                in_res_taken,
  output logic                out_full,
  output logic                out_empty,
  output logic                out_hit_valid,
  output logic [1:0]          out_hit,
  output logic [PC_WIDTH-1:0] out_update_PC,
  output logic                out_mispredict,
  output logic                out_err
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]         out_stat_branches,
  output logic [15:0]         out_stat_mispred
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [PC_WIDTH-1:0] pc_mem [DEPTH];
  logic [DEPTH-1:0] bim_mem, gsh_mem, fin_mem;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic pop, push, mis;
  assign out_full = count == (AW+1)'(DEPTH);
  assign out_empty = count == '0;
  assign pop = in_res_valid && !out_empty;
  assign mis = pop && (fin_mem[rd_ptr] != in_res_taken);
  assign push = in_pred_valid && (!out_full || pop);
  always_ff @(posedge in_Clk or negedge in_Rst_N)
    if (!in_Rst_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      out_hit_valid <= 1'b0;
      out_hit <= '0;
      out_update_PC <= '0;
      out_mispredict <= 1'b0;
      out_err <= 1'b0;
    end else begin
      out_hit_valid <= pop;
      out_mispredict <= mis;
      if (pop) begin
        out_hit <= {gsh_mem[rd_ptr] == in_res_taken, bim_mem[rd_ptr] == in_res_taken};
        out_update_PC <= pc_mem[rd_ptr];
      end
      if ((in_pred_valid && !push) || (in_res_valid && !pop)) out_err <= 1'b1;
      // a mispredict makes every younger entry (and any same-cycle push) wrong-path
      if (mis) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  always_ff @(posedge in_Clk)
    if (push && !mis) begin
      pc_mem[wr_ptr] <= in_PC;
      bim_mem[wr_ptr] <= in_pred_bimodal;
      gsh_mem[wr_ptr] <= in_pred_gshare;
      fin_mem[wr_ptr] <= in_pred_final;
    end
`ifdef BRU_STATS_EN
  always_ff @(posedge in_Clk or negedge in_Rst_N)
    if (!in_Rst_N) begin
      out_stat_branches <= '0;
      out_stat_mispred <= '0;
    end else begin
      if (pop && out_stat_branches != 16'hFFFF) out_stat_branches <= out_stat_branches + 1'b1;
      if (mis && out_stat_mispred != 16'hFFFF) out_stat_mispred <= out_stat_mispred + 1'b1;
    end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vector table plus hand sequences for the branch resolve queue.
module tb_branch_resolve_unit;
  logic clk = 0, rst_n = 0;
  logic pv = 0, b = 0, g = 0, f = 0, rv = 0, t = 0;
  logic [8:0] pc = 0;
  logic full, empty, hv, mis, err;
  logic [1:0] hit;
  logic [8:0] upc;
`ifdef BRU_STATS_EN
  logic [15:0] st_br, st_mp;
`endif
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  branch_resolve_unit #(.DEPTH(4), .PC_WIDTH(9)) dut (
    .in_Clk(clk), .in_Rst_N(rst_n), .in_pred_valid(pv), .in_PC(pc),
    .in_pred_bimodal(b), .in_pred_gshare(g), .in_pred_final(f),
    .in_res_valid(rv), .in_res_taken(t), .out_full(full), .out_empty(empty),
    .out_hit_valid(hv), .out_hit(hit), .out_update_PC(upc),
    .out_mispredict(mis), .out_err(err)
`ifdef BRU_STATS_EN
    , .out_stat_branches(st_br), .out_stat_mispred(st_mp)
`endif
  );
  typedef struct {
    logic rst, pv; logic [8:0] pc; logic b, g, f, rv, t;
    logic hv; logic [1:0] hit; logic [8:0] upc; logic mis, full, empty, err;
  } vec_t;
  vec_t vt [21];
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask
  task automatic chk_all(input int idx, input logic e_hv, input logic [1:0] e_hit, input logic [8:0] e_upc,
                         input logic e_mis, input logic e_full, input logic e_empty, input logic e_err);
    chk("hit_valid", idx, 32'(hv), 32'(e_hv));
    chk("hit", idx, 32'(hit), 32'(e_hit));
    chk("update_pc", idx, 32'(upc), 32'(e_upc));
    chk("mispredict", idx, 32'(mis), 32'(e_mis));
    chk("full", idx, 32'(full), 32'(e_full));
    chk("empty", idx, 32'(empty), 32'(e_empty));
    chk("err", idx, 32'(err), 32'(e_err));
  endtask
  task automatic drive(input logic i_pv, input logic [8:0] i_pc, input logic i_b, input logic i_g,
                       input logic i_f, input logic i_rv, input logic i_t);
    pv = i_pv; pc = i_pc; b = i_b; g = i_g; f = i_f; rv = i_rv; t = i_t;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_rst;
    rst_n = 0;
    #1;
    rst_n = 1;
  endtask
  initial begin
    vt[0]  = '{0,1,9'h012,1,0,1,0,0, 0,2'b00,9'h000,0,0,0,0};
    vt[1]  = '{0,0,9'h000,0,0,0,0,0, 0,2'b00,9'h000,0,0,0,0};
    vt[2]  = '{0,0,9'h000,0,0,0,1,1, 1,2'b01,9'h012,0,0,1,0};
    vt[3]  = '{0,1,9'h001,0,0,0,0,0, 0,2'b01,9'h012,0,0,0,0};
    vt[4]  = '{0,1,9'h002,0,0,0,0,0, 0,2'b01,9'h012,0,0,0,0};
    vt[5]  = '{0,1,9'h003,0,0,0,0,0, 0,2'b01,9'h012,0,0,0,0};
    vt[6]  = '{0,0,9'h000,0,0,0,1,1, 1,2'b00,9'h001,1,0,1,0};
    vt[7]  = '{0,0,9'h000,0,0,0,1,1, 0,2'b00,9'h001,0,0,1,1};
    vt[8]  = '{1,1,9'h004,0,0,0,0,0, 0,2'b00,9'h000,0,0,0,0};
    vt[9]  = '{0,1,9'h005,0,0,0,0,0, 0,2'b00,9'h000,0,0,0,0};
    vt[10] = '{0,1,9'h006,0,0,0,0,0, 0,2'b00,9'h000,0,0,0,0};
    vt[11] = '{0,1,9'h007,0,0,0,0,0, 0,2'b00,9'h000,0,1,0,0};
    vt[12] = '{0,1,9'h008,0,0,0,0,0, 0,2'b00,9'h000,0,1,0,1};
    vt[13] = '{0,1,9'h009,0,0,0,1,0, 1,2'b11,9'h004,0,1,0,1};
    vt[14] = '{0,0,9'h000,0,0,0,1,0, 1,2'b11,9'h005,0,0,0,1};
    vt[15] = '{0,0,9'h000,0,0,0,1,0, 1,2'b11,9'h006,0,0,0,1};
    vt[16] = '{0,0,9'h000,0,0,0,1,0, 1,2'b11,9'h007,0,0,0,1};
    vt[17] = '{0,0,9'h000,0,0,0,1,0, 1,2'b11,9'h009,0,0,1,1};
    vt[18] = '{1,1,9'h00A,0,0,0,0,0, 0,2'b00,9'h000,0,0,0,0};
    vt[19] = '{0,1,9'h00B,0,0,0,1,1, 1,2'b00,9'h00A,1,0,1,0};
    vt[20] = '{0,0,9'h000,0,0,0,0,0, 0,2'b00,9'h00A,0,0,1,0};
    #12;
    chk_all(-1, 0, 2'b00, 9'h000, 0, 0, 1, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 21; i++) begin
      if (vt[i].rst) pulse_rst();
      drive(vt[i].pv, vt[i].pc, vt[i].b, vt[i].g, vt[i].f, vt[i].rv, vt[i].t);
      chk_all(i, vt[i].hv, vt[i].hit, vt[i].upc, vt[i].mis, vt[i].full, vt[i].empty, vt[i].err);
    end
    // back-to-back stream of ten correctly predicted branches, wrapping the pointers
    pulse_rst();
    drive(1, 9'h100, 1, 1, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      drive(i < 10, 9'(9'h100 + i), 1, 1, 1, 1, 1);
      chk_all(100 + i, 1, 2'b11, 9'(9'h100 + i - 1), 0, 0, i == 10, 0);
    end
    // asynchronous reset with entries queued and a hit pulse live
    for (int i = 0; i < 4; i++) drive(1, 9'(9'h040 + i), 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk_all(200, 1, 2'b11, 9'h040, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    chk_all(201, 0, 2'b00, 9'h000, 0, 0, 1, 0);
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 1, 1);
    chk_all(202, 0, 2'b00, 9'h000, 0, 0, 1, 1);
`ifdef BRU_STATS_EN
    pulse_rst();
    for (int i = 0; i < 5; i++) begin
      drive(1, 9'(i), 0, 0, i < 3, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 1);
    end
    #1;
    chk("stat_branches", 300, 32'(st_br), 32'd5);
    chk("stat_mispred", 300, 32'(st_mp), 32'd2);
    drive(1, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 65540; i++) drive(1, 9'(i), 1, 1, 1, 1, 1);
    chk("stat_branches", 301, 32'(st_br), 32'hFFFF);
    chk("stat_mispred", 301, 32'(st_mp), 32'd2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution-side counterpart of the branch prediction unit. It records every prediction issued at fetch in an in-order queue.
- When a branch resolves in EX, it pops the oldest entry and compares the actual outcome against each component prediction.
- It drives the per-predictor 2-bit hit vector back into the BPU and raises a mispredict/flush to the front end.
- It sits between IF (push side) and EX (resolve side) in the RV64IF pipeline.

Parameters:
- DEPTH, 4, queue entries for in-flight branches; power of two, minimum 2.
- PC_WIDTH, 9, width of the PC index bits stored per entry; matches the BPU PC index.

Ports:
- in_Clk  input  1  clock, rising edge
- in_Rst_N  input  1  reset, asynchronous, active-low
- in_pred_valid  input  1  fetch issued a predicted branch this cycle (push)
- in_PC  input  PC_WIDTH  PC index of that branch
- in_pred_bimodal  input  1  bimodal (predictor 0) direction, 1 = taken
- in_pred_gshare  input  1  gshare (predictor 1) direction
- in_pred_final  input  1  selected prediction actually followed by fetch
- in_res_valid  input  1  oldest outstanding branch resolves this cycle (pop)
- in_res_taken  input  1  actual direction of the resolving branch
- out_full  output  1  queue full; fetch must stall further branch issue
- out_empty  output  1  queue empty
- out_hit_valid  output  1  one-cycle pulse; out_hit and out_update_PC are valid
- out_hit  output  2  bit0 = bimodal correct, bit1 = gshare correct (BPU in_hit encoding)
- out_update_PC  output  PC_WIDTH  PC index of the resolved branch, used for table update
- out_mispredict  output  1  one-cycle pulse; the final prediction was wrong, flush younger
- out_err  output  1  sticky error: overflow push or underflow resolve

Behaviour:
- Reset (async on in_Rst_N low): queue empty, read/write pointers 0, count 0. All outputs 0 except out_empty = 1. Reset mid-operation discards all entries immediately.
- Entry fields: {PC, bimodal, gshare, final}, written at the write pointer on an accepted push.
- Push accepted when in_pred_valid = 1 and either (count < DEPTH) or (a valid pop happens in the same cycle).
- Push while full with no pop: dropped; out_err set.
- Pop valid when in_res_valid = 1 and count > 0.
- Resolve while empty: ignored; no out_hit_valid pulse; out_err set.
- Valid pop, cycle N; all outputs registered, latency 1, observed at N+1:
  - out_hit_valid = 1
  - out_hit[0] = (bimodal == in_res_taken)
  - out_hit[1] = (gshare == in_res_taken)
  - out_update_PC = entry PC
  - out_mispredict = (final != in_res_taken)
  - At N+1 with no pop at N, out_hit_valid and out_mispredict return to 0. out_hit and out_update_PC hold their last values.
- Flush: on a valid pop at N whose final != taken, the queue is cleared at the N edge (count 0, pointers equal), so out_empty = 1 at N+1. All younger entries are wrong-path. A push in the same cycle N is also discarded and does not set out_err.
- Simultaneous push and pop without mispredict: count unchanged; head advances; tail written.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- out_full = (count == DEPTH); out_empty = (count == 0); both derived from registered count.
- out_err clears only on reset.

Optional Feature:
- Macro BRU_STATS_EN.
- When defined, adds outputs out_stat_branches[15:0] and out_stat_mispred[15:0]:
  - Both are saturating counters, reset to 0.
  - out_stat_branches increments on every valid pop.
  - out_stat_mispred increments on every pop with a mispredict.
  - Both stop at 16'hFFFF.
- When not defined, neither the ports nor the counters exist, and core behaviour is identical.

Test Plan:
- Reset, then push PC=9'h012 (bimodal 1, gshare 0, final 1); resolve taken=1 two cycles later -> next cycle out_hit_valid=1, out_hit=2'b01, out_update_PC=9'h012, out_mispredict=0, out_empty=1.
- Push 3 entries (PC 1,2,3, all predictions 0); resolve first with taken=1 -> out_mispredict=1, out_hit=2'b00, out_update_PC=1; next cycle out_empty=1. A following resolve produces no pulse and sets out_err=1.
- Push DEPTH=4 entries -> out_full=1. A 5th push alone is dropped and sets out_err. Push plus correct pop in the same cycle while full -> count stays 4 and the new entry is retained. Draining gives PCs in FIFO order.
- Stream 10 push/pop pairs back-to-back with all predictions correct -> ten consecutive out_hit_valid pulses, out_hit=2'b11, pointers wrap correctly, no out_err.
- Assert in_Rst_N low mid-stream with 3 entries queued -> outputs 0 immediately and out_empty=1. After release, a resolve produces no pulse.
- With BRU_STATS_EN: 5 resolves, 2 of them mispredicted -> out_stat_branches=5, out_stat_mispred=2. Force 65540 resolves -> out_stat_branches saturates at 16'hFFFF.
